// File: rtl/sync_fifo_stream_if.sv
// Stream-side bundle of the synchronous FIFO: write port, read port,
// occupancy status, programmable thresholds and sticky error flags.
// The master modport is the user of the FIFO; the slave modport is the FIFO.
interface sync_fifo_stream_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Control and write side
  logic                  i_clr;
  logic                  i_wr_en;
  logic [DATA_WIDTH-1:0] i_wr_data;

  // Read side
  logic                  i_rd_en;
  logic [DATA_WIDTH-1:0] o_rd_data;
  logic                  o_rd_valid;

  // Occupancy
  logic                  o_full;
  logic                  o_empty;
  logic [CW-1:0]         o_count;

  // Programmable watermarks
  logic [CW-1:0]         i_afull_thr;
  logic [CW-1:0]         i_aempty_thr;
  logic                  o_almost_full;
  logic                  o_almost_empty;

  // Sticky error flags
  logic                  o_overflow;
  logic                  o_underflow;

  modport master (
    output i_clr,
    output i_wr_en,
    output i_wr_data,
    output i_rd_en,
    output i_afull_thr,
    output i_aempty_thr,
    input  o_rd_data,
    input  o_rd_valid,
    input  o_full,
    input  o_empty,
    input  o_count,
    input  o_almost_full,
    input  o_almost_empty,
    input  o_overflow,
    input  o_underflow
  );

  modport slave (
    input  i_clr,
    input  i_wr_en,
    input  i_wr_data,
    input  i_rd_en,
    input  i_afull_thr,
    input  i_aempty_thr,
    output o_rd_data,
    output o_rd_valid,
    output o_full,
    output o_empty,
    output o_count,
    output o_almost_full,
    output o_almost_empty,
    output o_overflow,
    output o_underflow
  );
endinterface

// File: rtl/sync_fifo_stream.sv
// Synchronous single-clock FIFO with a selectable read mode.
//   FWFT=0 : standard mode, an accepted read returns its word one cycle later.
//   FWFT=1 : first-word-fall-through, the head word is always presented with
//            o_rd_valid while the FIFO holds data; i_rd_en pops it.
// Storage is an inferred RAM with a registered read port. In FWFT mode the
// output stage is a copy of the head entry, not an extra slot, so capacity is
// exactly DEPTH words in both modes and o_count always reports words held.
module sync_fifo_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter bit FWFT       = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  sync_fifo_stream_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // ------------------------------------------------------------------
  // Storage and state
  // ------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] ram_q_reg;

  // Pointers carry one bit above the address so that "same slot, different
  // lap" (full) can be told apart from "same slot, same lap" (empty).
  logic [CW-1:0] wr_ptr_reg;
  logic [CW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;

  logic overflow_reg;
  logic underflow_reg;
  logic rd_valid_reg;

  logic          full;
  logic          empty;
  logic          wr_ok;
  logic          rd_ok;
  logic          ram_re;
  logic [AW-1:0] ram_addr;

  // ------------------------------------------------------------------
  // Status and handshake acceptance (all from pre-edge state)
  // ------------------------------------------------------------------
  // Full when the write pointer is exactly one lap ahead of the read pointer;
  // this always coincides with count_reg == DEPTH since both move together.
  assign full  = (wr_ptr_reg == {~rd_ptr_reg[AW], rd_ptr_reg[AW-1:0]});

  // In FWFT mode the output stage is occupied exactly when the FIFO holds
  // data, so emptiness is read straight off the valid flag.
  assign empty = FWFT ? !rd_valid_reg : (count_reg == '0);

  // Flush wins over both ports: nothing is stored or consumed in that cycle.
  assign wr_ok = bus.i_wr_en && !full  && !bus.i_clr;
  assign rd_ok = bus.i_rd_en && !empty && !bus.i_clr;

  assign bus.o_full         = full;
  assign bus.o_empty        = empty;
  assign bus.o_count        = count_reg;
  assign bus.o_rd_valid     = rd_valid_reg;
  assign bus.o_overflow     = overflow_reg;
  assign bus.o_underflow    = underflow_reg;

  // Watermarks compare live thresholds against the registered count.
  assign bus.o_almost_full  = (count_reg >= bus.i_afull_thr);
  assign bus.o_almost_empty = (count_reg <= bus.i_aempty_thr);

  // ------------------------------------------------------------------
  // RAM
  // ------------------------------------------------------------------
  // Write port: accepted words land at the tail slot.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_reg[AW-1:0]] <= bus.i_wr_data;
    end
  end

  // Registered read port with enable; holds its last word when idle.
  always_ff @(posedge clk) begin
    if (ram_re) begin
      ram_q_reg <= mem[ram_addr];
    end
  end

  // ------------------------------------------------------------------
  // Pointers and occupancy counter
  // ------------------------------------------------------------------
  // Advance pointers on accepted transfers; reset and flush return to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (bus.i_clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_reg <= wr_ptr_reg + CW'(1);
      end
      if (rd_ok) begin
        rd_ptr_reg <= rd_ptr_reg + CW'(1);
      end
    end
  end

  // Count moves only when exactly one side transfers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (bus.i_clr) begin
      count_reg <= '0;
    end else begin
      case ({wr_ok, rd_ok})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Sticky error flags
  // ------------------------------------------------------------------
  // Record any write attempt while full and any read attempt while empty;
  // cleared only by reset or flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (bus.i_clr) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (bus.i_wr_en && full) begin
        overflow_reg <= 1'b1;
      end
      if (bus.i_rd_en && empty) begin
        underflow_reg <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Read-side output stage
  // ------------------------------------------------------------------
  generate
    if (FWFT) begin : gen_fwft
      logic                  load_ram;
      logic                  load_byp;
      logic                  sel_byp_reg;
      logic [DATA_WIDTH-1:0] byp_data_reg;

      // After a pop, the next head is already in RAM when at least two words
      // were held; prefetch it so it is presented without a bubble.
      assign load_ram = rd_ok && (count_reg > CW'(1));

      // The next head is the word being written right now when the FIFO is
      // empty, or when its only word is popped in the same cycle. The RAM
      // cannot return that word yet, so it is captured from the write port.
      assign load_byp = wr_ok &&
                        ((count_reg == '0) || (rd_ok && (count_reg == CW'(1))));

      assign ram_re   = load_ram;
      assign ram_addr = rd_ptr_reg[AW-1:0] + AW'(1);

      // Bypass capture of a freshly written head word.
      always_ff @(posedge clk) begin
        if (load_byp) begin
          byp_data_reg <= bus.i_wr_data;
        end
      end

      // Track which source holds the presented word and whether one exists.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sel_byp_reg  <= 1'b0;
          rd_valid_reg <= 1'b0;
        end else if (bus.i_clr) begin
          sel_byp_reg  <= 1'b0;
          rd_valid_reg <= 1'b0;
        end else if (load_byp) begin
          sel_byp_reg  <= 1'b1;
          rd_valid_reg <= 1'b1;
        end else if (load_ram) begin
          sel_byp_reg  <= 1'b0;
          rd_valid_reg <= 1'b1;
        end else if (rd_ok) begin
          rd_valid_reg <= 1'b0;
        end
      end

      assign bus.o_rd_data = sel_byp_reg ? byp_data_reg : ram_q_reg;

    end else begin : gen_std
      // Standard mode: fetch the head on the accepted read edge.
      assign ram_re   = rd_ok;
      assign ram_addr = rd_ptr_reg[AW-1:0];

      // Valid for exactly the cycle after an accepted read. A read accepted
      // just before a flush still delivers its word during the flush cycle.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rd_valid_reg <= 1'b0;
        end else begin
          rd_valid_reg <= rd_ok;
        end
      end

      assign bus.o_rd_data = ram_q_reg;
    end
  endgenerate

endmodule
